// File: rtl/reg_file_sb_pkg.sv
// Shared definitions for the register file / write-pending scoreboard slice.
package reg_file_sb_pkg;

    // Reset-contents selector values for INIT_INDEX
    localparam int INIT_MODE_ZERO  = 32'sd0;
    localparam int INIT_MODE_INDEX = 32'sd1;

    // Largest value a PEND_W-bit outstanding-write counter may hold
    function automatic int pend_max(input int pend_w);
        return (32'sd1 <<< pend_w) - 32'sd1;
    endfunction

endpackage

// File: rtl/reg_file_sb_sb_counter.sv
// Single-register outstanding-write counter: saturating up/down with clear.
// Increment at max and decrement at zero are silently suppressed.
module sb_counter
    import reg_file_sb_pkg::*;
#(
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    input  logic              dec,
    output logic [PEND_W-1:0] cnt,
    output logic              full,
    output logic              empty
);

    localparam logic [PEND_W-1:0] CNT_MAX  = PEND_W'(pend_max(PEND_W));
    localparam logic [PEND_W-1:0] CNT_ZERO = {PEND_W{1'b0}};
    localparam logic [PEND_W-1:0] CNT_ONE  = PEND_W'(1);

    logic [PEND_W-1:0] cnt_q;
    logic [PEND_W-1:0] cnt_d;
    logic              inc_ok_s;
    logic              dec_ok_s;

    // Next count: clear wins, a matched inc/dec pair cancels out
    always_comb begin
        cnt_d    = cnt_q;
        inc_ok_s = inc && (cnt_q != CNT_MAX);
        dec_ok_s = dec && (cnt_q != CNT_ZERO);
        if (clr) begin
            cnt_d = CNT_ZERO;
        end else if (inc_ok_s && !dec_ok_s) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (dec_ok_s && !inc_ok_s) begin
            cnt_d = cnt_q - CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt   = cnt_q;
    assign full  = (cnt_q == CNT_MAX);
    assign empty = (cnt_q == CNT_ZERO);

endmodule

// File: rtl/reg_file_sb.sv
// Register file with two bypassed read ports and a per-register
// write-pending scoreboard that drives the ID-stage stall.
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NUM_REGS   = 15,
    parameter int ADDR_W     = 4,
    parameter int PEND_W     = 2,
    parameter int INIT_INDEX = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    input  logic              rd_use1,
    input  logic              rd_use2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_dest,
    input  logic              flush,
    output logic              hazard,
    output logic              issue_full,
    output logic              sb_err
);

    localparam logic [ADDR_W:0]   NUM_REGS_L = (ADDR_W+1)'(NUM_REGS);
    localparam logic [PEND_W-1:0] CNT_ONE    = PEND_W'(1);
    localparam logic [DATA_W-1:0] DATA_ZERO  = {DATA_W{1'b0}};

    // Address lies inside the implemented register range
    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} < NUM_REGS_L);
    endfunction

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              sb_err_q;
    logic              sb_err_d;

    logic [PEND_W-1:0]   cnt_s [NUM_REGS];
    logic [NUM_REGS-1:0] inc_s;
    logic [NUM_REGS-1:0] dec_s;
    logic [NUM_REGS-1:0] full_s;
    logic [NUM_REGS-1:0] empty_s;
    logic [NUM_REGS-1:0] pend_eff_s;

    // One scoreboard counter per implemented register
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_sb
        assign inc_s[g] = issue_en && !flush && (issue_dest == ADDR_W'(g));
        assign dec_s[g] = wb_en && (wb_addr == ADDR_W'(g));
        // The final outstanding write retiring now is covered by the bypass
        assign pend_eff_s[g] = !empty_s[g] && !((cnt_s[g] == CNT_ONE) && dec_s[g]);

        sb_counter #(
            .PEND_W (PEND_W)
        ) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .clr   (flush),
            .inc   (inc_s[g]),
            .dec   (dec_s[g]),
            .cnt   (cnt_s[g]),
            .full  (full_s[g]),
            .empty (empty_s[g])
        );
    end

    // Storage next-state: in-range write-back only
    always_comb begin
        regs_d = regs_q;
        if (wb_en && in_range(wb_addr)) begin
            regs_d[wb_addr] = wb_data;
        end else begin
            regs_d = regs_q;
        end
    end

    // Storage flops, reset to index or zero depending on INIT_INDEX
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (INIT_INDEX == INIT_MODE_INDEX) ? DATA_W'(i) : DATA_ZERO;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports: out-of-range gives zero, same-cycle write-back bypasses
    always_comb begin
        rd_data1 = DATA_ZERO;
        rd_data2 = DATA_ZERO;
        if (!in_range(rd_addr1)) begin
            rd_data1 = DATA_ZERO;
        end else if (wb_en && (wb_addr == rd_addr1)) begin
            rd_data1 = wb_data;
        end else begin
            rd_data1 = regs_q[rd_addr1];
        end
        if (!in_range(rd_addr2)) begin
            rd_data2 = DATA_ZERO;
        end else if (wb_en && (wb_addr == rd_addr2)) begin
            rd_data2 = wb_data;
        end else begin
            rd_data2 = regs_q[rd_addr2];
        end
    end

    // Saturation detect and stall request to the hazard unit
    always_comb begin
        issue_full = 1'b0;
        hazard     = 1'b0;
        if (issue_en && in_range(issue_dest)) begin
            issue_full = full_s[issue_dest];
        end else begin
            issue_full = 1'b0;
        end
        if (rd_use1 && in_range(rd_addr1) && pend_eff_s[rd_addr1]) begin
            hazard = 1'b1;
        end else if (rd_use2 && in_range(rd_addr2) && pend_eff_s[rd_addr2]) begin
            hazard = 1'b1;
        end else begin
            hazard = issue_full;
        end
    end

    // Sticky error: an issue was attempted against a saturated counter
    always_comb begin
        sb_err_d = sb_err_q;
        if (issue_full) begin
            sb_err_d = 1'b1;
        end else begin
            sb_err_d = sb_err_q;
        end
    end

    // Error flag register, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_err_q <= 1'b0;
        end else begin
            sb_err_q <= sb_err_d;
        end
    end

    assign sb_err = sb_err_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Randomized and directed bench for reg_file_sb against a behavioural model.
module tb_reg_file_sb;

    localparam int NR  = 15;
    localparam int MAX = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  rd_addr1, rd_addr2, wb_addr, issue_dest;
    logic        rd_use1, rd_use2, wb_en, issue_en, flush;
    logic [31:0] wb_data;
    logic [31:0] rd_data1, rd_data2, z_rd_data1, z_rd_data2;
    logic        hazard, issue_full, sb_err, z_hazard, z_issue_full, z_sb_err;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural reference state
    logic [31:0] mdl_reg [NR];
    int          mdl_cnt [NR];
    bit          mdl_err;

    always #5 clk = ~clk;

    reg_file_sb dut (
        .clk(clk), .rst(rst), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_use1(rd_use1), .rd_use2(rd_use2), .rd_data1(rd_data1), .rd_data2(rd_data2),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .issue_en(issue_en), .issue_dest(issue_dest), .flush(flush),
        .hazard(hazard), .issue_full(issue_full), .sb_err(sb_err)
    );

    reg_file_sb #(.INIT_INDEX(0)) dut_zero (
        .clk(clk), .rst(rst), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_use1(rd_use1), .rd_use2(rd_use2), .rd_data1(z_rd_data1), .rd_data2(z_rd_data2),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .issue_en(issue_en), .issue_dest(issue_dest), .flush(flush),
        .hazard(z_hazard), .issue_full(z_issue_full), .sb_err(z_sb_err)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit ok(input logic [3:0] a);
        return int'(a) < NR;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [3:0] a);
        if (!ok(a)) return 32'd0;
        if (wb_en && wb_addr == a) return wb_data;
        return mdl_reg[a];
    endfunction

    function automatic bit exp_pend(input logic [3:0] a);
        if (!ok(a)) return 1'b0;
        if (mdl_cnt[a] == 0) return 1'b0;
        return !(mdl_cnt[a] == 1 && wb_en && wb_addr == a);
    endfunction

    function automatic bit exp_full();
        return issue_en && ok(issue_dest) && mdl_cnt[issue_dest] == MAX;
    endfunction

    function automatic bit exp_hazard();
        return (rd_use1 && exp_pend(rd_addr1)) || (rd_use2 && exp_pend(rd_addr2)) || exp_full();
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            mdl_reg[i] = 32'(i);
            mdl_cnt[i] = 0;
        end
        mdl_err = 1'b0;
    endtask

    task automatic model_clock();
        bit inc, dec;
        if (exp_full()) mdl_err = 1'b1;
        if (flush) begin
            for (int i = 0; i < NR; i++) mdl_cnt[i] = 0;
        end else begin
            inc = issue_en && ok(issue_dest) && mdl_cnt[issue_dest] != MAX;
            dec = wb_en && ok(wb_addr) && mdl_cnt[wb_addr] != 0;
            if (!(inc && dec && issue_dest == wb_addr)) begin
                if (inc) mdl_cnt[issue_dest] += 1;
                if (dec) mdl_cnt[wb_addr] -= 1;
            end
        end
        if (wb_en && ok(wb_addr)) mdl_reg[wb_addr] = wb_data;
    endtask

    task automatic check_outputs();
        check_val("rd_data1", rd_data1, exp_rd(rd_addr1));
        check_val("rd_data2", rd_data2, exp_rd(rd_addr2));
        check_val("hazard", 32'(hazard), 32'(exp_hazard()));
        check_val("issue_full", 32'(issue_full), 32'(exp_full()));
        check_val("sb_err", 32'(sb_err), 32'(mdl_err));
    endtask

    // Called at posedge+1; checks mid-cycle, then advances model on the edge
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic idle();
        rd_addr1 = 4'd0; rd_addr2 = 4'd0; rd_use1 = 1'b0; rd_use2 = 1'b0;
        wb_en = 1'b0; wb_addr = 4'd0; wb_data = 32'd0;
        issue_en = 1'b0; issue_dest = 4'd0; flush = 1'b0;
    endtask

    function automatic logic [3:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return 4'($urandom_range(0, 15));
        return 4'($urandom_range(0, 3));
    endfunction

    initial begin
        idle();
        model_reset();
        // Reset state of both init modes
        rd_addr1 = 4'd5; rd_addr2 = 4'd14;
        #1 rst = 1'b1;
        #1;
        check_val("rst_rd1", rd_data1, 32'd5);
        check_val("rst_rd2", rd_data2, 32'd14);
        check_val("rst_hazard", 32'(hazard), 32'd0);
        check_val("rst_sb_err", 32'(sb_err), 32'd0);
        check_val("rst0_rd1", z_rd_data1, 32'd0);
        check_val("rst0_rd2", z_rd_data2, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Same-cycle bypass, then stored value
        idle(); wb_en = 1'b1; wb_addr = 4'd3; wb_data = 32'hDEADBEEF; rd_addr1 = 4'd3;
        #1 check_val("bypass", rd_data1, 32'hDEADBEEF);
        cycle();
        idle(); rd_addr1 = 4'd3;
        #1 check_val("stored", rd_data1, 32'hDEADBEEF);

        // Scoreboard stall on a single in-flight write
        idle(); issue_en = 1'b1; issue_dest = 4'd7;
        cycle();
        idle(); rd_addr1 = 4'd7; rd_use1 = 1'b1;
        #1 check_val("stall_use", 32'(hazard), 32'd1);
        rd_use1 = 1'b0;
        #1 check_val("stall_nouse", 32'(hazard), 32'd0);
        rd_use1 = 1'b1; wb_en = 1'b1; wb_addr = 4'd7; wb_data = 32'h55;
        #1 check_val("wb_release", 32'(hazard), 32'd0);
        check_val("wb_release_data", rd_data1, 32'h55);
        cycle();

        // Saturation on register 2
        idle(); issue_en = 1'b1; issue_dest = 4'd2;
        for (int i = 0; i < 3; i++) cycle();
        #1 check_val("sat_full", 32'(issue_full), 32'd1);
        check_val("sat_hazard", 32'(hazard), 32'd1);
        cycle();
        check_val("sat_err", 32'(sb_err), 32'd1);
        idle(); rd_addr1 = 4'd2; rd_use1 = 1'b1; wb_en = 1'b1; wb_addr = 4'd2;
        for (int i = 0; i < 3; i++) begin
            wb_data = 32'h100 + 32'(i);
            #1 check_val("drain_hazard", 32'(hazard), (i < 2) ? 32'd1 : 32'd0);
            cycle();
        end

        // Issue and write-back to the same register cancel; flush clears
        idle(); issue_en = 1'b1; issue_dest = 4'd4;
        cycle();
        wb_en = 1'b1; wb_addr = 4'd4; wb_data = 32'h1234;
        cycle();
        idle(); rd_addr1 = 4'd4; rd_use1 = 1'b1;
        #1 check_val("cancel_hazard", 32'(hazard), 32'd1);
        check_val("cancel_data", rd_data1, 32'h1234);
        flush = 1'b1; issue_en = 1'b1; issue_dest = 4'd4;
        cycle();
        idle(); rd_addr1 = 4'd4; rd_use1 = 1'b1;
        #1 check_val("flush_hazard", 32'(hazard), 32'd0);

        // Out-of-range register index
        idle(); rd_addr1 = 4'd15; rd_addr2 = 4'd15; rd_use1 = 1'b1; rd_use2 = 1'b1;
        wb_en = 1'b1; wb_addr = 4'd15; wb_data = 32'hFFFF_FFFF;
        issue_en = 1'b1; issue_dest = 4'd15;
        #1 check_val("oor_rd1", rd_data1, 32'd0);
        check_val("oor_hazard", 32'(hazard), 32'd0);
        check_val("oor_full", 32'(issue_full), 32'd0);
        cycle();

        // Randomized traffic, with one reset in the middle
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) begin
                idle();
                rst = 1'b1;
                model_reset();
                #1 check_outputs();
                @(posedge clk);
                #1 rst = 1'b0;
            end
            rd_addr1   = rnd_addr();
            rd_addr2   = rnd_addr();
            rd_use1    = 1'($urandom_range(0, 1));
            rd_use2    = 1'($urandom_range(0, 1));
            wb_en      = ($urandom_range(0, 9) < 4);
            wb_addr    = rnd_addr();
            wb_data    = $urandom();
            issue_en   = ($urandom_range(0, 9) < 5);
            issue_dest = rnd_addr();
            flush      = ($urandom_range(0, 39) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
